conv_encoder_framed: RTL

CONV_ENCODER_FRAMED -- requirements
Module: conv_encoder_framed

---
 rtl/conv_encoder_framed.sv | 128 ++++++++++++
 1 files changed

// File: rtl/conv_encoder_framed.sv
// Framed rate-1/2 K=4 convolutional encoder (g1=1111, g0=1101), MSB first, 3-bit zero tail per frame.
// Latency: first coded pair 1 cycle after the accepting edge; ready_o only in IDLE/WAIT or at bit 0 when more bytes are due.
module conv_encoder_framed #(
   parameter int FRAME_LEN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [1:0] d_out,
   output logic       valid_o,
   output logic       frame_start_o,
   output logic       busy_o
);

   typedef enum logic [1:0] {IDLE, DATA, WAIT, TAIL} state_t;

   localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

   state_t     state, state_nxt;
   logic [2:0] s, s_nxt;
   logic [2:0] idx, idx_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic [7:0] byte_q, byte_nxt;
   logic [1:0] d_nxt;
   logic       valid_nxt, fs_nxt;
   logic       rdy, take, u, code_en;

   assign rdy     = (state == IDLE) || (state == WAIT) ||
                    ((state == DATA) && (idx == 3'd0) && (cnt < LAST));
   assign ready_o = rdy & rst;
   assign take    = valid_i & ready_o;
   assign busy_o  = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         s             <= 3'b000;
         idx           <= 3'd7;
         cnt           <= 8'd0;
         byte_q        <= 8'd0;
         d_out         <= 2'b00;
         valid_o       <= 1'b0;
         frame_start_o <= 1'b0;
      end else begin
         state         <= state_nxt;
         s             <= s_nxt;
         idx           <= idx_nxt;
         cnt           <= cnt_nxt;
         byte_q        <= byte_nxt;
         d_out         <= d_nxt;
         valid_o       <= valid_nxt;
         frame_start_o <= fs_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      byte_nxt  = byte_q;
      d_nxt     = 2'b00;
      valid_nxt = 1'b0;
      fs_nxt    = 1'b0;
      u         = 1'b0;
      code_en   = 1'b0;

      case (state)
         IDLE: begin
            s_nxt = 3'b000;
            if (take) begin
               byte_nxt  = data_i;
               idx_nxt   = 3'd7;
               cnt_nxt   = 8'd0;
               state_nxt = DATA;
            end
         end
         DATA: begin
            u       = byte_q[idx];
            code_en = 1'b1;
            fs_nxt  = (idx == 3'd7) && (cnt == 8'd0);
            idx_nxt = idx - 3'd1;
            if (idx == 3'd0) begin
               if (cnt == LAST) begin
                  idx_nxt   = 3'd2;
                  state_nxt = TAIL;
               end else if (take) begin
                  // next byte follows on the very next cycle, no gap
                  byte_nxt = data_i;
                  idx_nxt  = 3'd7;
                  cnt_nxt  = cnt + 8'd1;
               end else begin
                  idx_nxt   = 3'd7;
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (take) begin
               byte_nxt  = data_i;
               idx_nxt   = 3'd7;
               cnt_nxt   = cnt + 8'd1;
               state_nxt = DATA;
            end
         end
         TAIL: begin
            code_en = 1'b1;
            idx_nxt = idx - 3'd1;
            if (idx == 3'd0) begin
               idx_nxt   = 3'd7;
               cnt_nxt   = 8'd0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // three zero shifts in TAIL leave the register at 000
      if (code_en) begin
         d_nxt     = {u ^ s[0] ^ s[1] ^ s[2], u ^ s[0] ^ s[2]};
         valid_nxt = 1'b1;
         s_nxt     = {s[1:0], u};
      end
   end

endmodule
